// File: rtl/key_load_ctrl_if.sv
// rtl/key_load_ctrl_if.sv - one-bit-per-beat serial key stream with valid/ready handshake
interface key_load_ctrl_if;
    logic ser_valid;
    logic ser_data;
    logic ser_ready;

    // Key source side: presents bits, observes acceptance
    modport master (
        output ser_valid,
        output ser_data,
        input  ser_ready
    );

    // Controller side: consumes bits, signals acceptance
    modport slave (
        input  ser_valid,
        input  ser_data,
        output ser_ready
    );
endinterface

// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - deserialise, parity-check and commit the logic-lock unlock key
module key_load_ctrl #(
    parameter int KEY_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    key_load_ctrl_if.slave       ser,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // A single-bit key still needs a one-bit counter
    localparam int CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(KEY_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic [KEY_WIDTH-1:0] shadow;
    logic                 beat;
    logic                 parity_ok;

    // Handshake and status decode purely from registered state
    assign ser.ser_ready = (state == LOAD) || (state == CHECK);
    assign busy          = (state != IDLE);
    assign beat          = ser.ser_valid & ser.ser_ready;
    // Even parity over key plus trailing bit
    assign parity_ok     = (ser.ser_data == ^shadow);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start outside IDLE has no effect
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (beat && (cnt == LAST)) state_nxt = CHECK;
            CHECK:   if (beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow shift-in, commit on good parity, clear on bad parity
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            shadow    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        shadow    <= '0;
                        err       <= 1'b0;
                        key_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        shadow[cnt] <= ser.ser_data;
                        // Hold at the last index so cnt stays within the key
                        if (cnt != LAST) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (beat) begin
                        done <= 1'b1;
                        if (parity_ok) begin
                            key_out   <= shadow;
                            key_valid <= 1'b1;
                            err       <= 1'b0;
                        end else begin
                            key_out   <= '0;
                            key_valid <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/key_load_ctrl.md
# key_load_ctrl

Sequencer that loads the unlock key into a logic-locked netlist's key-input ports (keyIn0_0 … keyIn0_{N-1}). It deserialises a key delivered one bit per beat over a valid/ready stream and checks it against a trailing parity bit. On a good load it commits the key to a held register that drives the locked circuit. Until a good key is committed, the key register is zero and key_valid is low, so downstream logic can gate the locked circuit's outputs.

## Interface
- KEY_WIDTH, 4, number of key bits; key_out[i] drives keyIn0_i of the locked netlist; minimum 1
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a key load; sampled only in IDLE
- ser_valid  input  1  serial source has a bit on ser_data
- ser_data  input  1  key/parity bit
- ser_ready  output  1  controller accepts a bit this cycle
- key_out  output  KEY_WIDTH  committed key, to the locked netlist key ports
- key_valid  output  1  key_out holds a parity-checked key
- busy  output  1  load in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse when a load finishes, good or bad
- err  output  1  last load failed parity; sticky until the next start

## Operation
- States: IDLE, LOAD, CHECK.
- IDLE:
  - ser_ready = 0.
  - start = 1 → LOAD; clear bit counter, shadow register and err; drop key_valid.
  - key_out keeps its old value until commit.
- LOAD:
  - ser_ready = 1. A beat is ser_valid & ser_ready.
  - Each beat writes ser_data into shadow[cnt] and increments cnt. Bit order is LSB first: the first beat is key bit 0.
  - The beat with cnt = KEY_WIDTH-1 → CHECK.
- CHECK:
  - ser_ready = 1. The beat is the parity bit p.
  - Pass: p == XOR-reduce(shadow), i.e. even parity over key plus p.
    - key_out ← shadow, key_valid ← 1, err ← 0.
  - Fail: key_out ← 0, key_valid ← 0, err ← 1.
  - Either case: done pulses and the state returns to IDLE.
- No beats are accepted outside LOAD/CHECK. ser_valid without ser_ready is ignored, and data is not consumed.
- start while busy is ignored; no restart and no effect.
- Counter width is $clog2(KEY_WIDTH) with a minimum of 1. cnt never exceeds KEY_WIDTH-1.
- Reset, including mid-load:
  - state IDLE, cnt 0, shadow 0.
  - key_out 0, key_valid 0, busy 0, done 0, err 0, ser_ready 0.
  - A partially shifted key is discarded and never reaches key_out.

## Timing
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- start high at edge T (in IDLE):
  - busy = 1, ser_ready = 1 and key_valid = 0 from cycle T+1.
  - The first beat can be accepted at edge T+1.
- With ser_valid held high, a full load takes KEY_WIDTH+1 beats.
  - With start at T, the parity beat falls at edge T+KEY_WIDTH+1.
  - key_out, key_valid, err, done update and busy falls at cycle T+KEY_WIDTH+2.
- Stall cycles (ser_valid = 0) stretch the load one cycle each. There is no timeout.
- done is high exactly one cycle. A new start is accepted on the cycle done is high (state is IDLE).
- key_out changes only at commit, on a parity fail (→ 0), or on reset.

## Test plan
- Good load, KEY_WIDTH = 4:
  - start, then beats 0,1,0,1 (key 4'hA), parity 0.
  - → key_out = 4'hA, key_valid = 1, err = 0, done one cycle, busy low 6 cycles after start.
- Bad parity:
  - Key 4'hA, parity 1.
  - → key_out = 4'h0, key_valid = 0, err = 1, done pulses.
  - A following good load of 4'h7 (parity 1) → key_out = 4'h7, err = 0.
- Stalls:
  - 4'hC with ser_valid low for 3 random cycles between beats.
  - → commit is delayed by exactly the stall count; no bits are taken while ser_valid = 0.
- Reload and ignore rules:
  - With 4'hA committed, start again.
    - → key_valid = 0 from the next cycle while key_out stays 4'hA until the new commit.
  - start pulsed mid-load → ignored; the bit sequence completes normally.
- Reset mid-load:
  - After 2 of 4 beats, assert rst for 1 cycle.
  - → all outputs 0, state IDLE, ser_ready = 0.
  - A fresh load of 4'h5 (parity 0) commits 4'h5 correctly.
